// File: rtl/fetch_stage.sv
// Instruction fetch stage with a single-outstanding-request memory port.
// PCF addresses the memory. A redirect (PCSrcE) can arrive while a request
// is in flight; the response to that request is then discarded. A response
// that arrives during a stall is parked in a one-word buffer. The IF/ID
// register can be held (StallF) or bubbled (FlushD).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request PCF this cycle
    S_WAIT = 2'd1,  // request granted, waiting for its response
    S_DROP = 2'd2,  // request granted but redirected; discard its response
    S_HOLD = 2'd3   // response parked in the hold buffer during a stall
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic        wr_s;        // IF/ID write due this cycle
  logic [31:0] wr_data_s;   // word to write into IF/ID
  logic [31:0] pcf_plus4_s;

  assign pcf_plus4_s = pcf_q + 32'd4;

  // Memory request is a decode of the registered state; the address is PCF.
  assign ImemReq  = (state_q == S_REQ);
  assign ImemAddr = pcf_q;

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

  // Next-state, next-PC and hold-buffer logic; redirect outranks stall.
  always_comb begin
    state_d   = state_q;
    pcf_d     = pcf_q;
    hold_d    = hold_q;
    wr_s      = 1'b0;
    wr_data_s = ImemRData;
    case (state_q)
      S_REQ: begin
        if (PCSrcE) begin
          pcf_d = PCTargetE;
        end else begin
          pcf_d = pcf_q;
        end
        if (ImemGnt) begin
          state_d = PCSrcE ? S_DROP : S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (ImemRValid) begin
          if (PCSrcE) begin
            pcf_d   = PCTargetE;
            state_d = S_REQ;
          end else if (StallF) begin
            hold_d  = ImemRData;
            state_d = S_HOLD;
          end else begin
            wr_s      = 1'b1;
            wr_data_s = ImemRData;
            pcf_d     = pcf_plus4_s;
            state_d   = S_REQ;
          end
        end else if (PCSrcE) begin
          pcf_d   = PCTargetE;
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        if (PCSrcE) begin
          pcf_d = PCTargetE;
        end else begin
          pcf_d = pcf_q;
        end
        if (ImemRValid) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          hold_d  = 32'h0000_0000;
          pcf_d   = PCTargetE;
          state_d = S_REQ;
        end else if (!StallF) begin
          wr_s      = 1'b1;
          wr_data_s = hold_q;
          pcf_d     = pcf_plus4_s;
          state_d   = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_REQ;
        pcf_d   = RESET_PC;
        hold_d  = 32'h0000_0000;
      end
    endcase
  end

  // IF/ID register next value: flush beats write, write beats stall.
  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (FlushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (wr_s) begin
      instr_d = wr_data_s;
      pcd_d   = pcf_q;
      pcp4_d  = pcf_plus4_s;
      valid_d = 1'b1;
    end else if (StallF) begin
      valid_d = valid_q;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // State, PC, hold buffer and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pcf_q   <= RESET_PC;
      hold_q  <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
      pcd_q   <= 32'h0000_0000;
      pcp4_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be the reset: one clock, synchronous, active-high.
REQ-004 Port StallF, input, 1 bit, SHALL hold the PC and the IF/ID register.
REQ-005 Port FlushD, input, 1 bit, SHALL turn the IF/ID register into a bubble.
REQ-006 Port PCSrcE, input, 1 bit, SHALL be the redirect request (taken branch/jump).
REQ-007 Port PCTargetE, input, 32 bits, SHALL be the redirect target address.
REQ-008 Ports ImemReq (output, 1), ImemAddr (output, 32), ImemGnt (input, 1), ImemRValid (input, 1) and ImemRData (input, 32) SHALL form the instruction memory interface.
REQ-009 Ports InstrD (output, 32), PCD (output, 32), PCPlus4D (output, 32) and ValidD (output, 1) SHALL be the IF/ID register; InstrD[31:7] feeds immediate extension in decode.

Function
REQ-010 Internal PCF register (32 bits); ImemAddr SHALL equal PCF combinationally at all times.
REQ-011 FSM states SHALL be REQ, WAIT, DROP and HOLD; ImemReq SHALL be 1 only in REQ; at most one request SHALL be outstanding.
REQ-012 REQ: ImemGnt=1 with PCSrcE=0 -> WAIT; ImemGnt=1 with PCSrcE=1 -> DROP and PCF<=PCTargetE; ImemGnt=0 with PCSrcE=1 -> PCF<=PCTargetE, stay in REQ.
REQ-013 WAIT, ImemRValid=1:
- PCSrcE=1 -> discard data, PCF<=PCTargetE, go to REQ.
- else StallF=1 -> capture data into a 32-bit hold buffer, go to HOLD.
- else write IF/ID, PCF<=PCF+4, go to REQ.
REQ-014 WAIT, ImemRValid=0, PCSrcE=1 -> PCF<=PCTargetE, go to DROP.
REQ-015 DROP: ImemRValid=1 -> discard data, go to REQ; PCSrcE=1 in DROP -> PCF<=PCTargetE, stay in DROP until the response arrives.
REQ-016 HOLD: PCSrcE=1 -> discard buffer, PCF<=PCTargetE, go to REQ; else StallF=0 -> write IF/ID from buffer, PCF<=PCF+4, go to REQ; else stay.
REQ-017 ImemRValid SHALL be ignored in REQ and HOLD.
REQ-018 An IF/ID write SHALL load InstrD<=data, PCD<=PCF, PCPlus4D<=PCF+4 (modulo 2^32, wrapping at 0xFFFFFFFC) and ValidD<=1.
REQ-019 No write due, StallF=0 -> bubble: ValidD<=0, InstrD<=32'h0000_0013; PCD and PCPlus4D hold.
REQ-020 StallF=1 and FlushD=0 -> IF/ID SHALL hold all values.
REQ-021 FlushD=1 -> bubble regardless of StallF or a pending write, and the write that cycle SHALL be lost; FSM and PCF SHALL be unaffected by FlushD. The hazard unit asserts FlushD only together with PCSrcE.
REQ-022 PCSrcE SHALL take priority over StallF for PCF updates.
REQ-023 Throughput with single-cycle memory SHALL be one instruction per two cycles; latency from grant to ValidD=1 SHALL be one cycle after ImemRValid.

Reset
REQ-024 reset=1 at an edge SHALL set PCF=RESET_PC and state=REQ, clear the hold buffer, and set InstrD=32'h0000_0013, PCD=0, PCPlus4D=0, ValidD=0; this overrides all other inputs.
REQ-025 Reset mid-transaction SHALL abandon the outstanding request; the memory is reset with the block.

Verification
REQ-026 Release reset; memory grants immediately with ImemRValid one cycle after grant -> ImemAddr sequence 0,4,8; IF/ID shows PCD 0/4/8, PCPlus4D 4/8/C, ValidD=1 every second cycle.
REQ-027 StallF=1 for 3 cycles spanning ImemRValid -> state HOLD, IF/ID unchanged; first cycle after release, InstrD equals the buffered word.
REQ-028 PCSrcE=1, PCTargetE=0x100 during WAIT before ImemRValid -> DROP, stale word never reaches InstrD; next ImemAddr=0x100.
REQ-029 PCSrcE=1 in the same cycle as ImemGnt in REQ -> DROP, response discarded, next request to PCTargetE.
REQ-030 FlushD=1 with StallF=1 -> next cycle ValidD=0, InstrD=32'h0000_0013.
REQ-031 reset asserted in WAIT, then a late ImemRValid in REQ -> ignored; ImemAddr=RESET_PC, ValidD=0.
